// File: rtl/smac_layer_seq.sv
// smac_layer_seq: layer sequencer for the SMAC AC3 output-count path.
//
// Keeps a per-layer table of {max_val, passes}. On start it walks through
// num_layers entries. For each layer it clears the AC3 done counter, loads it
// with the layer's max_val, then counts rising edges of done_ac3 until the
// layer's pass count is reached. It is the only driver of the done counter's
// clear, load and max_val inputs.
//
// Optional feature: define SMAC_SEQ_ABORT_EN to add the abort input.
//
// Ports
//   clk          clock; all logic on the rising edge
//   rst          synchronous, active-high reset
//   cfg_we       table write strobe (ignored while busy)
//   cfg_addr     table entry to write
//   cfg_max      max_val for the entry
//   cfg_passes   done_ac3 edges that complete the layer (0 behaves as 1)
//   num_layers   layers to run, sampled on an accepted start (clamped to NL)
//   start        one-cycle run request (honoured only in IDLE)
//   abort        (SMAC_SEQ_ABORT_EN only) cancel the sequence
//   done_ac3     done level from the counter; held high until the next valid
//   last_fil     last-filter level from the counter
//   cnt_clear    counter clear pulse
//   cnt_load     counter load pulse
//   max_val      value presented with cnt_load; held between loads
//   layer_idx    current layer
//   pass_cnt     passes completed in the current layer (saturating)
//   last_pass    last_fil seen during the final pass of the layer
//   busy         sequence active
//   seq_done     one-cycle completion pulse
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start
// CLEAR  | cnt_clear pulse; edge detector reset; exit point of an abort
// LOAD   | cnt_load pulse with the layer's max_val
// RUN    | counting done_ac3 rising edges
// NEXT   | advance to the next layer or finish
// FIN    | seq_done pulse, busy already low

module smac_layer_seq #(
  parameter int MNO = 288,
  parameter int NL  = 8,
  parameter int PW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(NL)-1:0]    cfg_addr,
  input  logic [$clog2(MNO)-1:0]   cfg_max,
  input  logic [PW-1:0]            cfg_passes,
  input  logic [$clog2(NL+1)-1:0]  num_layers,
  input  logic                     start,
`ifdef SMAC_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     done_ac3,
  input  logic                     last_fil,
  output logic                     cnt_clear,
  output logic                     cnt_load,
  output logic [$clog2(MNO)-1:0]   max_val,
  output logic [$clog2(NL)-1:0]    layer_idx,
  output logic [PW-1:0]            pass_cnt,
  output logic                     last_pass,
  output logic                     busy,
  output logic                     seq_done
);

  localparam int MW = $clog2(MNO);
  localparam int AW = $clog2(NL);
  localparam int LW = $clog2(NL+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state;
  logic [MW-1:0] tbl_max    [NL];
  logic [PW-1:0] tbl_passes [NL];
  logic [LW-1:0] nl_lat;
  logic          done_prev;
  logic          aborting;
  logic          abort_req;

  logic          done_rise;
  logic [PW-1:0] eff_passes;
  logic [PW:0]   pass_inc;
  logic [PW-1:0] pass_sat;
  logic          final_hit;
  logic          last_layer;
  logic [LW-1:0] nl_clamp;

`ifdef SMAC_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // done_ac3 is a level that stays high until the next valid, so only the
  // rising edge counts as a pass.
  assign done_rise  = done_ac3 & ~done_prev;
  assign eff_passes = (tbl_passes[layer_idx] == '0) ? PW'(1) : tbl_passes[layer_idx];
  assign pass_inc   = {1'b0, pass_cnt} + (PW+1)'(1);
  assign pass_sat   = pass_inc[PW] ? pass_cnt : pass_inc[PW-1:0];
  assign final_hit  = pass_inc >= {1'b0, eff_passes};
  assign last_layer = (LW'(layer_idx) == (nl_lat - LW'(1)));
  assign nl_clamp   = (num_layers > LW'(NL)) ? LW'(NL) : num_layers;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_clear <= 1'b0;
      cnt_load  <= 1'b0;
      max_val   <= '0;
      layer_idx <= '0;
      pass_cnt  <= '0;
      last_pass <= 1'b0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
      nl_lat    <= '0;
      done_prev <= 1'b0;
      aborting  <= 1'b0;
      for (int i = 0; i < NL; i++) begin
        tbl_max[i]    <= '0;
        tbl_passes[i] <= '0;
      end
    end else begin
      cnt_clear <= 1'b0;
      cnt_load  <= 1'b0;
      seq_done  <= 1'b0;

      // Cleared in CLEAR and tracking the level in LOAD, so an edge arriving
      // in either cycle is absorbed before RUN starts counting.
      done_prev <= (state == S_CLEAR) ? 1'b0 : done_ac3;
      last_pass <= (state == S_RUN) && last_fil && final_hit;

      if (cfg_we && !busy && (int'(cfg_addr) < NL)) begin
        tbl_max[cfg_addr]    <= cfg_max;
        tbl_passes[cfg_addr] <= cfg_passes;
      end

      if (abort_req && (state != S_IDLE)) begin
        // Route through CLEAR so the counter is left cleared, then drop to IDLE.
        state     <= S_CLEAR;
        cnt_clear <= 1'b1;
        busy      <= 1'b1;
        aborting  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              nl_lat    <= nl_clamp;
              layer_idx <= '0;
              if (nl_clamp == '0) begin
                state    <= S_FIN;
                seq_done <= 1'b1;
                busy     <= 1'b0;
              end else begin
                state     <= S_CLEAR;
                cnt_clear <= 1'b1;
                busy      <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            if (aborting) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              aborting <= 1'b0;
            end else begin
              state    <= S_LOAD;
              cnt_load <= 1'b1;
              max_val  <= tbl_max[layer_idx];
              pass_cnt <= '0;
            end
          end
          S_LOAD: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (done_rise) begin
              pass_cnt <= pass_sat;
              if (final_hit) begin
                state <= S_NEXT;
              end
            end
          end
          S_NEXT: begin
            if (last_layer) begin
              state    <= S_FIN;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state     <= S_CLEAR;
              cnt_clear <= 1'b1;
              layer_idx <= layer_idx + AW'(1);
            end
          end
          S_FIN: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smac_layer_seq.sv
// Directed bench for smac_layer_seq. Expected max_val values are queued when a
// run is launched and popped by a monitor on every cnt_load.
module tb_smac_layer_seq;

  localparam int MNO = 288;
  localparam int NL  = 8;
  localparam int PW  = 16;
  localparam int MW  = $clog2(MNO);
  localparam int AW  = $clog2(NL);
  localparam int LW  = $clog2(NL+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [MW-1:0] cfg_max;
  logic [PW-1:0] cfg_passes;
  logic [LW-1:0] num_layers;
  logic          start;
`ifdef SMAC_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          done_ac3;
  logic          last_fil;
  logic          cnt_clear;
  logic          cnt_load;
  logic [MW-1:0] max_val;
  logic [AW-1:0] layer_idx;
  logic [PW-1:0] pass_cnt;
  logic          last_pass;
  logic          busy;
  logic          seq_done;

  int total = 0;
  int bad   = 0;
  int n_clr = 0;
  int n_load = 0;
  logic [31:0] exp_q[$];

  smac_layer_seq #(.MNO(MNO), .NL(NL), .PW(PW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_max(cfg_max), .cfg_passes(cfg_passes), .num_layers(num_layers),
    .start(start),
`ifdef SMAC_SEQ_ABORT_EN
    .abort(abort),
`endif
    .done_ac3(done_ac3), .last_fil(last_fil), .cnt_clear(cnt_clear),
    .cnt_load(cnt_load), .max_val(max_val), .layer_idx(layer_idx),
    .pass_cnt(pass_cnt), .last_pass(last_pass), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int a, input int m, input int p);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_max = MW'(m);
    cfg_passes = PW'(p);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: every load must match the next queued max_val.
  always @(negedge clk) begin
    logic [31:0] e;
    if (cnt_clear === 1'b1) n_clr++;
    if (cnt_load === 1'b1) begin
      n_load++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_load observed=%0d expected=none", max_val);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (32'(max_val) === e) else begin
          bad++;
          $error("FAIL load_max_val observed=%0d expected=%0d", max_val, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int l0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_max = '0; cfg_passes = '0;
    num_layers = '0; start = 1'b0; done_ac3 = 1'b0; last_fil = 1'b0;
`ifdef SMAC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    chk("rst_clear", 32'(cnt_clear), 0);
    chk("rst_load", 32'(cnt_load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(seq_done), 0);
    chk("rst_last_pass", 32'(last_pass), 0);
    chk("rst_max_val", 32'(max_val), 0);
    chk("rst_layer_idx", 32'(layer_idx), 0);
    chk("rst_pass_cnt", 32'(pass_cnt), 0);
    rst = 1'b0;
    tick();

    // Three-layer run: {4,2} {8,1} {2,3}
    cfg_wr(0, 4, 2); cfg_wr(1, 8, 1); cfg_wr(2, 2, 3);
    num_layers = 3;
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(2);
    c0 = n_clr;
    pulse_start();
    chk("t1_busy_start", 32'(busy), 1);
    chk("t1_clear_start", 32'(cnt_clear), 1);
    chk("t1_layer0", 32'(layer_idx), 0);
    tick();
    chk("t1_load0", 32'(cnt_load), 1);
    chk("t1_pass_reset", 32'(pass_cnt), 0);
    tick();
    chk("t1_busy_run0", 32'(busy), 1);
    done_ac3 = 1'b1;
    tick();
    chk("t1_pass_first", 32'(pass_cnt), 1);
    chk("t1_last_pass_lo", 32'(last_pass), 0);
    repeat (4) tick();
    chk("t1_hold_level", 32'(pass_cnt), 1);
    done_ac3 = 1'b0;
    tick();
    chk("t1_hold_after", 32'(pass_cnt), 1);
    done_ac3 = 1'b1; last_fil = 1'b1;
    tick();
    chk("t1_pass_second", 32'(pass_cnt), 2);
    chk("t1_last_pass_hi", 32'(last_pass), 1);
    chk("t1_busy_next", 32'(busy), 1);
    done_ac3 = 1'b0; last_fil = 1'b0;
    tick();
    chk("t1_clear1", 32'(cnt_clear), 1);
    chk("t1_layer1", 32'(layer_idx), 1);
    tick();
    chk("t1_gap_load1", 32'(cnt_load), 1);
    tick();
    done_ac3 = 1'b1;
    tick();
    chk("t1_l1_pass", 32'(pass_cnt), 1);
    done_ac3 = 1'b0;
    tick(); tick();
    chk("t1_layer2", 32'(layer_idx), 2);
    tick();
    for (int k = 1; k <= 3; k++) begin
      done_ac3 = 1'b1;
      tick();
      chk("t1_l2_pass", 32'(pass_cnt), 32'(k));
      done_ac3 = 1'b0;
      tick();
      if (k < 3) begin
        chk("t1_l2_busy", 32'(busy), 1);
        chk("t1_l2_no_done", 32'(seq_done), 0);
      end
    end
    chk("t1_seq_done", 32'(seq_done), 1);
    chk("t1_busy_fin", 32'(busy), 0);
    tick();
    chk("t1_done_pulse", 32'(seq_done), 0);
    chk("t1_clear_count", 32'(n_clr - c0), 3);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);

    // Zero layers: immediate completion, no counter pulses
    num_layers = 0;
    c0 = n_clr; l0 = n_load;
    pulse_start();
    chk("t2_seq_done", 32'(seq_done), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_clear", 32'(cnt_clear), 0);
    tick();
    chk("t2_done_pulse", 32'(seq_done), 0);
    chk("t2_no_clear", 32'(n_clr - c0), 0);
    chk("t2_no_load", 32'(n_load - l0), 0);

    // passes=0 acts as 1; write while busy is dropped
    cfg_wr(0, 5, 0);
    num_layers = 1;
    exp_q.push_back(5);
    pulse_start();
    cfg_we = 1'b1; cfg_addr = 0; cfg_max = 7; cfg_passes = 9;
    tick();
    cfg_we = 1'b0;
    tick();
    done_ac3 = 1'b1;
    tick();
    chk("t3_pass_one", 32'(pass_cnt), 1);
    done_ac3 = 1'b0;
    tick();
    chk("t3_seq_done", 32'(seq_done), 1);
    tick();
    // Readback run; done_ac3 rises during CLEAR and must not count
    exp_q.push_back(5);
    pulse_start();
    done_ac3 = 1'b1;
    tick(); tick(); tick();
    chk("t3_edge_in_clear_ignored", 32'(pass_cnt), 0);
    done_ac3 = 1'b0;
    tick();
    done_ac3 = 1'b1;
    tick();
    chk("t3_real_edge", 32'(pass_cnt), 1);
    done_ac3 = 1'b0;
    tick();
    chk("t3_seq_done2", 32'(seq_done), 1);
    tick();

    // num_layers above NL clamps to NL
    for (int i = 0; i < NL; i++) cfg_wr(i, i + 1, 0);
    for (int i = 0; i < NL; i++) exp_q.push_back(32'(i + 1));
    num_layers = 9;
    pulse_start();
    for (int i = 0; i < NL; i++) begin
      tick(); tick();
      done_ac3 = 1'b1;
      tick();
      done_ac3 = 1'b0;
      tick();
    end
    chk("t4_clamp_done", 32'(seq_done), 1);
    chk("t4_clamp_layer", 32'(layer_idx), NL - 1);
    tick();
    chk("t4_queue_empty", 32'(exp_q.size()), 0);

    // Reset during RUN of layer 1
    exp_q.push_back(1); exp_q.push_back(2);
    num_layers = 3;
    pulse_start();
    tick(); tick();
    done_ac3 = 1'b1;
    tick();
    done_ac3 = 1'b0;
    tick(); tick(); tick();
    chk("t5_in_layer1", 32'(layer_idx), 1);
    done_ac3 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; done_ac3 = 1'b0;
    chk("t5_clear", 32'(cnt_clear), 0);
    chk("t5_load", 32'(cnt_load), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(seq_done), 0);
    chk("t5_last_pass", 32'(last_pass), 0);
    chk("t5_max_val", 32'(max_val), 0);
    chk("t5_layer_idx", 32'(layer_idx), 0);
    chk("t5_pass_cnt", 32'(pass_cnt), 0);
    tick();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_clear", 32'(cnt_clear), 0);
    // Table was cleared by reset: every layer loads 0 and ends on one edge
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    pulse_start();
    chk("t5_restart_layer", 32'(layer_idx), 0);
    chk("t5_restart_clear", 32'(cnt_clear), 1);
    for (int i = 0; i < 3; i++) begin
      tick(); tick();
      done_ac3 = 1'b1;
      tick();
      done_ac3 = 1'b0;
      tick();
    end
    chk("t5_restart_done", 32'(seq_done), 1);
    tick();

`ifdef SMAC_SEQ_ABORT_EN
    cfg_wr(0, 3, 2);
    num_layers = 1;
    exp_q.push_back(3);
    pulse_start();
    tick(); tick();
    c0 = n_clr;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_clear", 32'(cnt_clear), 1);
    tick();
    chk("t6_abort_busy", 32'(busy), 0);
    chk("t6_abort_clear_end", 32'(cnt_clear), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_seq_done", 32'(seq_done), 0);
    end
    chk("t6_one_clear", 32'(n_clr - c0), 1);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
